instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset; 0 resets, 1 runs.
REQ-003 The block SHALL have port stall, input, 1 bit: decode not accepting; the buffered instruction is consumed on an edge where instr_valid=1 and stall=0.
REQ-004 The block SHALL have port redirect_valid, input, 1 bit: branch taken, from the PC_control pc_new path.
REQ-005 The block SHALL have port redirect_pc, input, 16 bits: redirect target, byte address.
REQ-006 The block SHALL have port imem_req, output, 1 bit: memory request.
REQ-007 The block SHALL have port imem_addr, output, 16 bits: request address.
REQ-008 The block SHALL have port imem_ready, input, 1 bit: one-cycle pulse completing the outstanding request.
REQ-009 The block SHALL have port imem_data, input, 16 bits: instruction word, valid when imem_ready=1.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: instruction buffer occupied.
REQ-011 The block SHALL have port instr, output, 16 bits: buffered instruction.
REQ-012 The block SHALL have port instr_pc, output, 16 bits: address of the buffered instruction.
REQ-013 The block SHALL have port pc_plus2, output, 16 bits: instr_pc+2 mod 2^16, combinational.
REQ-014 The block SHALL have port halted, output, 1 bit: high exactly while in state HALT.

Function
REQ-015 The block SHALL implement states IDLE, RUN, DRAIN and HALT, and SHALL hold internally pc[15:0], req_addr[15:0], an outstanding flag and a one-entry buffer (instr, instr_pc, instr_valid).
REQ-016 In IDLE, imem_req SHALL be 0 and the state SHALL be RUN at the next edge.
REQ-017 In RUN with outstanding=0, imem_req SHALL be 1 iff (instr_valid=0 or stall=0) and redirect_valid=0; at an edge with imem_req=1, req_addr SHALL load pc and outstanding SHALL set unless imem_ready=1 in the same cycle.
REQ-018 While outstanding=1, imem_req SHALL be 1 and imem_addr SHALL equal req_addr, independent of stall; otherwise imem_addr SHALL equal pc.
REQ-019 On imem_ready=1 in RUN with redirect_valid=0: instr<=imem_data, instr_pc<=imem_addr, instr_valid<=1, pc<=imem_addr+2 (0xFFFE wraps to 0x0000), outstanding<=0; if imem_data[15:12]=4'hF the state SHALL become HALT.
REQ-020 The buffer SHALL clear at a consume edge unless refilled at that same edge; combinational same-cycle imem_ready SHALL be supported, giving one instruction per cycle.
REQ-021 Redirect with no outstanding request (RUN or HALT): pc<=redirect_pc, instr_valid<=0, state RUN, no request issued that cycle.
REQ-022 Redirect with outstanding=1 and imem_ready=0: pc<=redirect_pc, instr_valid<=0, state DRAIN.
REQ-023 Redirect with imem_ready=1: the returned data SHALL be discarded, pc<=redirect_pc, instr_valid<=0, outstanding<=0, state RUN.
REQ-024 DRAIN SHALL hold imem_req=1 with imem_addr=req_addr until imem_ready, then discard the data and enter RUN; a further redirect in DRAIN SHALL only overwrite pc.
REQ-025 In HALT, imem_req SHALL be 0 and the buffered HLT instruction SHALL remain until consumed; only a redirect or reset SHALL leave HALT.
REQ-026 A request SHALL never be dropped or have its address changed before imem_ready; at most one request SHALL be outstanding.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, pc=0x0000, req_addr=0x0000, outstanding=0, instr_valid=0, instr=0x0000, instr_pc=0x0000, imem_req=0 and halted=0, including in the middle of DRAIN or an outstanding request.
REQ-028 The first request after deassertion SHALL be to 0x0000 one edge after leaving IDLE.

Verification
REQ-029 Reset then stall=0 and imem_ready one cycle after each request -> imem_addr 0x0000, 0x0002, 0x0004; instr_pc follows; pc_plus2 = instr_pc+2.
REQ-030 With instr_valid=1, stall=1 for 3 cycles -> instr/instr_pc stable, no new request; stall=0 -> request 0x0002 issued in that cycle.
REQ-031 Redirect 0x0040 while request 0x0004 is outstanding -> DRAIN, imem_addr held at 0x0004 until ready, data dropped, next request 0x0040, instr_valid=0 throughout.
REQ-032 Redirect 0x0040 coincident with imem_ready -> data dropped, next request 0x0040.
REQ-033 imem_data=0xF000 at 0x0006 -> instr_valid=1, halted=1 next cycle, imem_req=0 afterwards; redirect 0x0010 -> halted=0, request 0x0010.
REQ-034 Redirect 0xFFFE, fetch -> next request 0x0000; rst=0 mid-DRAIN -> all outputs at reset values, first request 0x0000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one-entry instruction buffer, a single outstanding
// memory request, redirect handling with drain of in-flight fetches, and HALT.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic        out_q, out_d;
  logic        vld_q, vld_d;
  logic [15:0] ins_q, ins_d;
  logic [15:0] ipc_q, ipc_d;
  logic        req_s;
  logic        consume_s;
  logic [15:0] addr_s;

  // An issued request keeps its address until the memory answers.
  assign addr_s    = out_q ? req_addr_q : pc_q;
  assign consume_s = vld_q & ~stall;

  // State register and fetch datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= 16'h0000;
      req_addr_q <= 16'h0000;
      out_q      <= 1'b0;
      vld_q      <= 1'b0;
      ins_q      <= 16'h0000;
      ipc_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
      ins_q      <= ins_d;
      ipc_q      <= ipc_d;
    end
  end

  // Next-state and request logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    out_d      = out_q;
    vld_d      = vld_q;
    ins_d      = ins_q;
    ipc_d      = ipc_q;
    req_s      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = RUN;
      end
      RUN: begin
        if (consume_s) vld_d = 1'b0;
        else           vld_d = vld_q;
        if (out_q) req_s = 1'b1;
        else       req_s = (~vld_q | ~stall) & ~redirect_valid;
        if (redirect_valid) begin
          pc_d  = redirect_pc;
          vld_d = 1'b0;
          if (out_q && !imem_ready) begin
            state_d = DRAIN;
          end else begin
            // Either nothing in flight or the returning word is discarded.
            out_d   = 1'b0;
            state_d = RUN;
          end
        end else if (req_s) begin
          req_addr_d = addr_s;
          if (imem_ready) begin
            ins_d = imem_data;
            ipc_d = addr_s;
            vld_d = 1'b1;
            pc_d  = addr_s + 16'd2;
            out_d = 1'b0;
            if (imem_data[15:12] == 4'hF) state_d = HALT;
            else                          state_d = RUN;
          end else begin
            out_d = 1'b1;
          end
        end else begin
          out_d = out_q;
        end
      end
      DRAIN: begin
        req_s = 1'b1;
        if (redirect_valid) pc_d = redirect_pc;
        else                pc_d = pc_q;
        if (imem_ready) begin
          out_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = DRAIN;
        end
      end
      HALT: begin
        if (consume_s) vld_d = 1'b0;
        else           vld_d = vld_q;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          vld_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req    = req_s;
  assign imem_addr   = addr_s;
  assign instr_valid = vld_q;
  assign instr       = ins_q;
  assign instr_pc    = ipc_q;
  assign pc_plus2    = ipc_q + 16'd2;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch: each record is one clock cycle
// of inputs together with the outputs expected during that cycle.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        halted;

  int n_checks;
  int n_fail;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus2       (pc_plus2),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] data;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_iv;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic s, input logic rv, input logic [15:0] rpc,
                   input logic rdy, input logic [15:0] data,
                   input logic e_req, input logic [15:0] e_addr, input logic e_iv,
                   input logic [15:0] e_instr, input logic [15:0] e_ipc,
                   input logic e_halt);
    vec_t t;
    t = '{s, rv, rpc, rdy, data, e_req, e_addr, e_iv, e_instr, e_ipc, e_halt};
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_ready = 1'b0; imem_data = 16'h0000;

    //  stall rv  rpc       rdy data      req addr      iv instr     ipc       halt
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0); // c0 IDLE
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h1111, 16'h0000, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000, 1'b0);
    v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h2222, 16'h0002, 1'b0); // stall x3
    v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h2222, 16'h0002, 1'b0);
    v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'h2222, 16'h0002, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 16'h0004, 1'b1, 16'h2222, 16'h0002, 1'b0); // same-cycle ready
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444, 1'b1, 16'h0006, 1'b1, 16'h3333, 16'h0004, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h4444, 16'h0006, 1'b0);
    v(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000, 1'b0); // redirect, outstanding
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000, 1'b0); // DRAIN
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0000, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 16'h6666, 16'h0040, 1'b0);
    v(1'b0, 1'b1, 16'h0080, 1'b1, 16'h7777, 1'b1, 16'h0042, 1'b0, 16'h0000, 16'h0000, 1'b0); // redirect + ready
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'hF000, 1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0000, 1'b0); // HLT fetched
    v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0082, 1'b1, 16'hF000, 16'h0080, 1'b1);
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0082, 1'b1, 16'hF000, 16'h0080, 1'b1);
    v(1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0082, 1'b0, 16'h0000, 16'h0000, 1'b1); // leave HALT
    v(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0);
    v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h8888, 16'hFFFE, 1'b0); // pc wrapped
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h8888, 16'hFFFE, 1'b0);
    v(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0); // in DRAIN

    // Reset state
    @(posedge clk); #1;
    chk("rst_req",   {15'd0, imem_req},    16'h0000);
    chk("rst_addr",  imem_addr,            16'h0000);
    chk("rst_iv",    {15'd0, instr_valid}, 16'h0000);
    chk("rst_halt",  {15'd0, halted},      16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      imem_ready     = vecs[i].rdy;
      imem_data      = vecs[i].data;
      #3;
      chk($sformatf("v%0d_req", i),  {15'd0, imem_req},    {15'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i), imem_addr,            vecs[i].e_addr);
      chk($sformatf("v%0d_iv", i),   {15'd0, instr_valid}, {15'd0, vecs[i].e_iv});
      chk($sformatf("v%0d_halt", i), {15'd0, halted},      {15'd0, vecs[i].e_halt});
      if (vecs[i].e_iv) begin
        chk($sformatf("v%0d_instr", i), instr,    vecs[i].e_instr);
        chk($sformatf("v%0d_ipc", i),   instr_pc, vecs[i].e_ipc);
        chk($sformatf("v%0d_pc2", i),   pc_plus2, vecs[i].e_ipc + 16'd2);
      end
      @(posedge clk); #1;
    end

    // Asynchronous reset in the middle of DRAIN
    stall = 1'b0; redirect_valid = 1'b0; imem_ready = 1'b0; imem_data = 16'h0000;
    rst = 1'b0;
    #1;
    chk("mid_rst_req",   {15'd0, imem_req},    16'h0000);
    chk("mid_rst_addr",  imem_addr,            16'h0000);
    chk("mid_rst_iv",    {15'd0, instr_valid}, 16'h0000);
    chk("mid_rst_instr", instr,                16'h0000);
    chk("mid_rst_ipc",   instr_pc,             16'h0000);
    chk("mid_rst_halt",  {15'd0, halted},      16'h0000);
    @(posedge clk); #1;
    rst = 1'b1;
    #3;
    chk("post_rst_idle_req", {15'd0, imem_req}, 16'h0000);
    @(posedge clk); #1; #3;
    chk("post_rst_req",  {15'd0, imem_req}, 16'h0001);
    chk("post_rst_addr", imem_addr,         16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
